// File: rtl/uart_apb_master_pkg.sv
// Shared definitions for the UART APB requester: FSM states, UART register map
// and a width helper for the optional ACCESS timeout counter.
package uart_apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam logic [31:0] UART_TX_ADDR = 32'h79;
    localparam logic [31:0] UART_RX_ADDR = 32'h78;

    // Bits needed to hold a count of 0..limit.
    function automatic int unsigned count_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles spent waiting for pready and flags when the wait limit
// is reached on the current cycle.
module apb_timeout_cnt #(
    parameter int unsigned CW = 8
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] limit,
    output logic          expired
);

    logic [CW-1:0] count;

    // Wait counter: restarts when a transfer enters ACCESS, advances on each unanswered ACCESS cycle.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // The cycle whose increment would reach the limit is the last ACCESS cycle allowed.
    assign expired = enable && (count == (limit - CW'(1)));

endmodule

// File: rtl/uart_apb_master.sv
// APB requester in front of uart_apb: one valid/ready command becomes one
// APB SETUP+ACCESS transfer, answered by a single-cycle response pulse.
// Optional feature macro: APB_TIMEOUT_EN (aborts an ACCESS phase that waits
// TIMEOUT_CYCLES cycles without pready).
module uart_apb_master
    import uart_apb_master_pkg::*;
#(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [DW-1:0] cmd_strb,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_tmo,
    output logic          busy,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] padd,
    output logic [DW-1:0] pwdata,
    output logic [DW-1:0] pstrb,
    input  logic [DW-1:0] prdata,
    input  logic          pready,
    input  logic          pslevrr
);

    apb_state_t    state;
    apb_state_t    state_next;
    logic          psel_next;
    logic          penable_next;
    logic          pwrite_next;
    logic [AW-1:0] padd_next;
    logic [DW-1:0] pwdata_next;
    logic [DW-1:0] pstrb_next;
    logic          rsp_valid_next;
    logic [DW-1:0] rsp_rdata_next;
    logic          rsp_err_next;
    logic          rsp_tmo_next;
    logic          timeout_expired;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

`ifdef APB_TIMEOUT_EN
    localparam int unsigned TMO_CW = count_width(TIMEOUT_CYCLES);

    logic tmo_clear;
    logic tmo_enable;

    assign tmo_clear  = (state == SETUP);
    assign tmo_enable = (state == ACCESS) && !pready;

    apb_timeout_cnt #(
        .CW (TMO_CW)
    ) u_timeout_cnt (
        .pclk    (pclk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .limit   (TMO_CW'(TIMEOUT_CYCLES)),
        .expired (timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    // Next-state and next-output decode; APB fields hold their latched values unless a command is accepted.
    always_comb begin
        state_next     = state;
        psel_next      = psel;
        penable_next   = penable;
        pwrite_next    = pwrite;
        padd_next      = padd;
        pwdata_next    = pwdata;
        pstrb_next     = pstrb;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = '0;
        rsp_err_next   = 1'b0;
        rsp_tmo_next   = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_next = cmd_write;
                    padd_next   = cmd_addr;
                    pwdata_next = cmd_wdata;
                    pstrb_next  = cmd_strb;
                    psel_next   = 1'b1;
                    state_next  = SETUP;
                end
            end
            SETUP: begin
                penable_next = 1'b1;
                state_next   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = pwrite ? '0 : prdata;
                    rsp_err_next   = pslevrr;
                    state_next     = IDLE;
                end else if (timeout_expired) begin
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    rsp_tmo_next   = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                psel_next    = 1'b0;
                penable_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any transfer in flight without a response.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            padd      <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_tmo   <= 1'b0;
        end else begin
            state     <= state_next;
            psel      <= psel_next;
            penable   <= penable_next;
            pwrite    <= pwrite_next;
            padd      <= padd_next;
            pwdata    <= pwdata_next;
            pstrb     <= pstrb_next;
            rsp_valid <= rsp_valid_next;
            rsp_rdata <= rsp_rdata_next;
            rsp_err   <= rsp_err_next;
            rsp_tmo   <= rsp_tmo_next;
        end
    end

endmodule
